// File: rtl/tt_um_div8_shiftsub.sv
// -----------------------------------------------------------------------------
// tt_um_div8_shiftsub
//
// Sequential 8-bit unsigned restoring (shift-subtract) divider in the Tiny
// Tapeout harness pinout. It computes (A << FRAC_BITS) / B. One quotient bit
// is produced per clock, so an operation takes 8 + FRAC_BITS cycles.
//
// Ports
//   clk      : clock
//   rst_n    : asynchronous, active-low reset
//   ena      : design select; when low every register holds its value
//   ui_in    : operand data bus (dividend / divisor)
//   uio_in   : [0] load_a, [1] load_b, [2] start, [3] sel, [7:4] unused
//   uo_out   : sel ? remainder : quotient (combinational mux of result regs)
//   uio_out  : [4] busy, [5] done, [6] div_by_zero, [7] overflow, [3:0] = 0
//   uio_oe   : constant 8'b1111_0000 (upper nibble driven as outputs)
//
// Parameter
//   FRAC_BITS : fractional quotient bits, legal range 0..7
// -----------------------------------------------------------------------------
module tt_um_div8_shiftsub #(
  parameter int FRAC_BITS = 0
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  // Working quotient width; also the number of iterations per operation.
  localparam int W = 8 + FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic       load_a, load_b, start, sel;
  logic       unused_uio_hi;

  logic [7:0]   a_q, b_q;        // operand registers
  logic [8:0]   rem_q;           // working partial remainder
  logic [W-1:0] shift_q;         // dividend bits out at MSB, quotient bits in at LSB
  logic [3:0]   cnt_q;           // iteration counter, N <= 15
  logic [7:0]   quot_res_q;      // registered quotient result
  logic [7:0]   rem_res_q;       // registered remainder result
  logic         dbz_q, ovf_q;

  logic [8:0]   rem_t, rem_d;
  logic         ge;
  logic [W-1:0] shift_d;
  logic [15:0]  q_wide;
  logic         q_over;
  logic         last_iter;
  logic         b_zero;

  assign load_a = uio_in[0];
  assign load_b = uio_in[1];
  assign start  = uio_in[2];
  assign sel    = uio_in[3];
  assign unused_uio_hi = &{1'b0, uio_in[7:4]};

  assign b_zero    = (b_q == 8'd0);
  assign last_iter = (cnt_q == 4'(W - 1));

  // One restoring step: bring in the next dividend bit, subtract B if it fits.
  // The same shift register that empties the dividend fills with quotient
  // bits, so after W steps it holds the complete quotient.
  assign rem_t   = {rem_q[7:0], shift_q[W-1]};
  assign ge      = (rem_t >= {1'b0, b_q});
  assign rem_d   = ge ? (rem_t - {1'b0, b_q}) : rem_t;
  assign shift_d = {shift_q[W-2:0], ge};

  // Any quotient bit above bit 7 means the result does not fit in 8 bits.
  assign q_wide = 16'(shift_d);
  assign q_over = |q_wide[15:8];

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = b_zero ? DONE : RUN;
      end
      RUN: begin
        if (last_iter) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand loads, iteration, result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      rem_q      <= 9'd0;
      shift_q    <= '0;
      cnt_q      <= 4'd0;
      quot_res_q <= 8'd0;
      rem_res_q  <= 8'd0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (ena) begin
      if (state_q != RUN) begin
        if (load_a) a_q <= ui_in;
        if (load_b) b_q <= ui_in;
        // A start in the same cycle as a load uses the previously held
        // operand values.
        if (start) begin
          ovf_q <= 1'b0;
          if (b_zero) begin
            dbz_q      <= 1'b1;
            quot_res_q <= 8'hFF;
            rem_res_q  <= a_q;
          end else begin
            dbz_q   <= 1'b0;
            rem_q   <= 9'd0;
            shift_q <= W'(a_q) << FRAC_BITS;
            cnt_q   <= 4'd0;
          end
        end
      end else begin
        rem_q   <= rem_d;
        shift_q <= shift_d;
        cnt_q   <= cnt_q + 4'd1;
        if (last_iter) begin
          quot_res_q <= q_over ? 8'hFF : q_wide[7:0];
          ovf_q      <= q_over;
          rem_res_q  <= rem_d[7:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign uo_out  = sel ? rem_res_q : quot_res_q;
  assign uio_out = {ovf_q, dbz_q, (state_q == DONE), (state_q == RUN), 4'b0000};
  assign uio_oe  = 8'b1111_0000;

endmodule

// File: tb/tb_tt_um_div8_shiftsub.sv
// -----------------------------------------------------------------------------
// tb_tt_um_div8_shiftsub
//
// Drives two divider instances from shared inputs: one with FRAC_BITS = 0 and
// one with FRAC_BITS = 4. Directed vectors with hand-computed results, plus
// sequences for latency, divide-by-zero, loads during RUN, ena stall and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_tt_um_div8_shiftsub;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo0, uio_out0, uio_oe0;
  logic [7:0] uo4, uio_out4, uio_oe4;

  int checks   = 0;
  int failures = 0;

  tt_um_div8_shiftsub #(.FRAC_BITS(0)) dut0 (
    .ui_in  (ui_in),
    .uo_out (uo0),
    .uio_in (uio_in),
    .uio_out(uio_out0),
    .uio_oe (uio_oe0),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  tt_um_div8_shiftsub #(.FRAC_BITS(4)) dut4 (
    .ui_in  (ui_in),
    .uo_out (uo4),
    .uio_in (uio_in),
    .uio_out(uio_out4),
    .uio_oe (uio_oe4),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected status byte values (uio_out) once an operation has finished.
  localparam logic [7:0] ST_DONE = 8'h20;
  localparam logic [7:0] ST_OVF  = 8'hA0;
  localparam logic [7:0] ST_DBZ  = 8'h60;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q0;
    logic [7:0] r0;
    logic [7:0] st0;
    logic [7:0] q4;
    logic [7:0] r4;
    logic [7:0] st4;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    ui_in  = a;
    uio_in = 8'h01;
    tick();
    ui_in  = b;
    uio_in = 8'h02;
    tick();
    uio_in = 8'h00;
  endtask

  task automatic pulse_start();
    uio_in = 8'h04;
    tick();
    uio_in = 8'h00;
  endtask

  // Wait until both instances report done, bounded to 40 cycles.
  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (uio_out0[5] && uio_out4[5]) begin
        ok = 1;
        break;
      end
      check({tag, "_busy_done_excl0"}, {31'd0, uio_out0[4] & uio_out0[5]}, 32'd0);
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done not seen within 40 cycles", tag);
    end
  endtask

  task automatic read_results(input string tag,
                              input logic [7:0] q0, input logic [7:0] r0, input logic [7:0] st0,
                              input logic [7:0] q4, input logic [7:0] r4, input logic [7:0] st4);
    uio_in[3] = 1'b0;
    #1;
    check({tag, "_q0"}, {24'd0, uo0}, {24'd0, q0});
    check({tag, "_q4"}, {24'd0, uo4}, {24'd0, q4});
    uio_in[3] = 1'b1;
    #1;
    check({tag, "_r0"}, {24'd0, uo0}, {24'd0, r0});
    check({tag, "_r4"}, {24'd0, uo4}, {24'd0, r4});
    uio_in[3] = 1'b0;
    #1;
    check({tag, "_st0"}, {24'd0, uio_out0}, {24'd0, st0});
    check({tag, "_st4"}, {24'd0, uio_out4}, {24'd0, st4});
  endtask

  // Start an operation and count clock edges after the start edge until each
  // instance shows done. Optionally drop ena for edges 4..6.
  task automatic run_timed(input logic [7:0] a, input logic [7:0] b, input bit drop,
                           output int lat0, output int lat4, output bit saw_busy);
    lat0 = -1;
    lat4 = -1;
    saw_busy = 0;
    load_ops(a, b);
    pulse_start();
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) tick();
      if (uio_out0[4] || uio_out4[4]) saw_busy = 1;
      if (lat0 < 0 && uio_out0[5]) lat0 = k;
      if (lat4 < 0 && uio_out4[5]) lat4 = k;
      if (lat0 >= 0 && lat4 >= 0) break;
      if (drop && k == 3) ena = 1'b0;
      if (drop && k == 6) ena = 1'b1;
    end
    ena = 1'b1;
  endtask

  initial begin
    int  lat0, lat4;
    bit  saw_busy;

    //           a     b     q0     r0     st0      q4     r4     st4
    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   ST_DONE, 8'hFF, 8'd1, ST_OVF };
    vecs[1] = '{8'd255, 8'd1,   8'hFF,  8'd0,   ST_DONE, 8'hFF, 8'd0, ST_OVF };
    vecs[2] = '{8'd3,   8'd10,  8'd0,   8'd3,   ST_DONE, 8'd4,  8'd8, ST_DONE};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   ST_DONE, 8'd16, 8'd0, ST_DONE};
    vecs[4] = '{8'd1,   8'd3,   8'd0,   8'd1,   ST_DONE, 8'd5,  8'd1, ST_DONE};
    vecs[5] = '{8'd200, 8'd3,   8'd66,  8'd2,   ST_DONE, 8'hFF, 8'd2, ST_OVF };
    vecs[6] = '{8'd100, 8'd200, 8'd0,   8'd100, ST_DONE, 8'd8,  8'd0, ST_DONE};
    vecs[7] = '{8'd5,   8'd0,   8'hFF,  8'd5,   ST_DBZ,  8'hFF, 8'd5, ST_DBZ };
    vecs[8] = '{8'd0,   8'd5,   8'd0,   8'd0,   ST_DONE, 8'd0,  8'd0, ST_DONE};
    vecs[9] = '{8'd15,  8'd16,  8'd0,   8'd15,  ST_DONE, 8'd15, 8'd0, ST_DONE};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;

    // Reset state
    #12;
    check("rst_uo0", {24'd0, uo0}, 32'd0);
    check("rst_uio0", {24'd0, uio_out0}, 32'd0);
    check("rst_uio4", {24'd0, uio_out4}, 32'd0);
    check("uio_oe0", {24'd0, uio_oe0}, 32'hF0);
    check("uio_oe4", {24'd0, uio_oe4}, 32'hF0);
    #11;
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      load_ops(vecs[i].a, vecs[i].b);
      pulse_start();
      wait_done(tag);
      read_results(tag, vecs[i].q0, vecs[i].r0, vecs[i].st0,
                   vecs[i].q4, vecs[i].r4, vecs[i].st4);
    end

    // Latency: 8 cycles for FRAC_BITS=0, 12 for FRAC_BITS=4
    run_timed(8'd200, 8'd7, 1'b0, lat0, lat4, saw_busy);
    check("lat0", lat0, 32'd8);
    check("lat4", lat4, 32'd12);
    read_results("lat", 8'd28, 8'd4, ST_DONE, 8'hFF, 8'd1, ST_OVF);

    // Divide-by-zero: done right after the start edge, busy never seen
    run_timed(8'd5, 8'd0, 1'b0, lat0, lat4, saw_busy);
    check("dbz_lat0", lat0, 32'd0);
    check("dbz_lat4", lat4, 32'd0);
    check("dbz_no_busy", {31'd0, saw_busy}, 32'd0);
    read_results("dbz", 8'hFF, 8'd5, ST_DBZ, 8'hFF, 8'd5, ST_DBZ);

    // ena dropped for 3 cycles mid-RUN
    run_timed(8'd200, 8'd7, 1'b1, lat0, lat4, saw_busy);
    check("ena_lat0", lat0, 32'd11);
    check("ena_lat4", lat4, 32'd15);
    read_results("ena", 8'd28, 8'd4, ST_DONE, 8'hFF, 8'd1, ST_OVF);

    // Loads during RUN are ignored
    load_ops(8'd90, 8'd9);
    pulse_start();
    ui_in  = 8'hFF;
    uio_in = 8'h01;
    tick();
    ui_in  = 8'h01;
    uio_in = 8'h02;
    tick();
    uio_in = 8'h00;
    wait_done("runload");
    read_results("runload", 8'd10, 8'd0, ST_DONE, 8'd160, 8'd0, ST_DONE);
    // Relaunch straight from DONE with the same registered operands
    pulse_start();
    check("b2b_busy0", {31'd0, uio_out0[4]}, 32'd1);
    wait_done("b2b");
    read_results("b2b", 8'd10, 8'd0, ST_DONE, 8'd160, 8'd0, ST_DONE);

    // Async reset mid-RUN
    load_ops(8'd200, 8'd7);
    pulse_start();
    tick();
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_uo0_q", {24'd0, uo0}, 32'd0);
    check("arst_uio0", {24'd0, uio_out0}, 32'd0);
    check("arst_uio4", {24'd0, uio_out4}, 32'd0);
    uio_in[3] = 1'b1;
    #1;
    check("arst_uo0_r", {24'd0, uo0}, 32'd0);
    uio_in[3] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_uio0", {24'd0, uio_out0}, 32'd0);
    check("post_rst_uio4", {24'd0, uio_out4}, 32'd0);
    check("post_rst_uo4", {24'd0, uo4}, 32'd0);
    load_ops(8'd200, 8'd7);
    pulse_start();
    wait_done("post_rst");
    read_results("post_rst", 8'd28, 8'd4, ST_DONE, 8'hFF, 8'd1, ST_OVF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_div8_shiftsub.md
Name: tt_um_div8_shiftsub

Overview:
Sequential 8-bit unsigned restoring divider (shift-subtract), the inverse companion of the shift-add multiplier.
It uses the same Tiny Tapeout harness pinout and sits behind the same top-level wrapper style.
Operands are loaded over ui_in under control of uio_in strobes.
Quotient or remainder is read on uo_out; status is driven on uio_out.

Parameters:
FRAC_BITS, 0, fixed-point fractional bits in the quotient (legal 0..7). The divider computes (A << FRAC_BITS) / B.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous assert, active-low
ena  input  1  design select; when low, all registers hold their value (reset still acts)
ui_in  input  8  operand data bus
uio_in  input  8  control: [0] load_a (dividend), [1] load_b (divisor), [2] start, [3] sel (0 = quotient, 1 = remainder); [7:4] ignored
uo_out  output  8  sel ? remainder : quotient, muxed combinationally from registered results
uio_out  output  8  [4] busy, [5] done, [6] div_by_zero, [7] overflow; [3:0] = 0
uio_oe  output  8  constant 8'b1111_0000

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; A, B, quotient and remainder registers = 0; all flags = 0.
  - Result: uo_out = 0x00, uio_out = 0x00. uio_oe is constant.
- Loads, sampled on the rising edge when ena = 1 and state != RUN:
  - load_a: A <= ui_in.
  - load_b: B <= ui_in.
  - If both are high, both registers take ui_in.
  - Loads during RUN are ignored; operands are latched into working registers at start.
- States:
  - IDLE: start = 1 → if B == 0 go to DONE next cycle with div_by_zero = 1; else go to RUN with cnt = 0, rem = 0, shift = {A, FRAC_BITS zeros}.
  - RUN, per cycle:
    - rem_t = {rem[7:0], shift MSB}.
    - If rem_t >= B: rem = rem_t - B and shift in q bit 1; else rem = rem_t and shift in q bit 0.
    - cnt++. Leave RUN after N = 8 + FRAC_BITS iterations.
  - DONE: results valid, done = 1. start = 1 launches a new operation exactly as from IDLE (no idle cycle required). done and div_by_zero/overflow clear on that launch edge.
  - load_a/load_b alone do not leave DONE.
- Widths:
  - Internal remainder is 9 bits. Internal quotient is 8 + FRAC_BITS bits.
  - If any quotient bit above bit 7 is set: quotient output = 0xFF saturated and overflow = 1. Otherwise quotient = low 8 bits.
  - Remainder output is 8 bits and is always < B.
- Divide-by-zero: quotient = 0xFF, remainder = A, div_by_zero = 1, overflow = 0.
- Latency:
  - start sampled on edge 0; busy = 1 from edge 0 through edge N-1.
  - done = 1 after edge N, i.e. result visible N cycles after the start edge.
  - Divide-by-zero: done after edge 0 (latency 1).
- busy is high exactly while state == RUN. busy and done are never both high.
- start held high in RUN is ignored. start held continuously re-launches from DONE each time DONE is reached.
- sel is purely combinational; switching it in any state changes uo_out in the same cycle.
- Reset mid-RUN: immediate return to the reset values; the partial result is discarded.
- ena low mid-RUN: the iteration freezes and resumes when ena returns high; the result equals the uninterrupted result.

Test Plan:
- FRAC_BITS=0: load A=200, B=7, start → busy for 8 cycles, then done=1; sel=0 gives uo_out=28 (0x1C), sel=1 gives 4.
- Edge values: 255/1 → q=0xFF, r=0. 3/10 → q=0, r=3. 255/255 → q=1, r=0. Flags 0 in all cases.
- Divide-by-zero: A=5, B=0, start → done after 1 cycle, uio_out[6]=1, q=0xFF, r=5, busy never asserted.
- FRAC_BITS=4 build:
  - 1/3 → q=5, r=1.
  - 200/3 → overflow=1, q=0xFF.
  - Latency is 12 cycles.
- Control robustness:
  - load_a=0xFF and load_b=0x01 during RUN are ignored; result matches the original operands.
  - Back-to-back start from DONE gives the correct second result.
  - ena dropped for 3 cycles mid-RUN gives a correct result, delayed by 3 cycles.
- Async reset: assert rst_n=0 at cycle 4 of RUN, mid-clock → uo_out=0 and uio_out=0 immediately. After release, state is IDLE and done=0 until a new start.
